id_ex_operand_stage: RTL and testbench

- Holds the ID/EX pipeline register for the 16-bit MIPS core and produces the final ALU operands `alu_a`, `alu_b` and `alu_ctrl`, which drive the ALU directly.
- Contains the EX/MEM and MEM/WB forwarding muxes.
- Contains the load-use hazard detector that stalls fetch/decode.
- Control bits not consumed in EX pass through to EX/MEM.

---
 rtl/id_ex_operand_stage.sv | 170 +++++++++++++++++
 tb/tb_id_ex_operand_stage.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register with EX-stage operand forwarding and load-use
// hazard detection for the 16-bit MIPS core. alu_a/alu_b/alu_ctrl drive the
// ALU directly. Remaining control bits pass through to EX/MEM.
//
// Flow control: no valid/ready handshake. hazard_stall is a combinational
// request to PC/IF-ID. Whenever it or flush is high at a rising edge, this
// register loads a bubble instead of the ID inputs. A bubble has every
// control bit low and every address/data field zero.
module id_ex_operand_stage #(
  parameter int DW = 16,
  parameter int RW = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic [DW-1:0] id_rs_data,
  input  logic [DW-1:0] id_rt_data,
  input  logic [DW-1:0] id_imm,
  input  logic [RW-1:0] id_rs,
  input  logic [RW-1:0] id_rt,
  input  logic [RW-1:0] id_rd,
  input  logic          id_alu_src,
  input  logic          id_reg_dst,
  input  logic [2:0]    id_alu_ctrl,
  input  logic          id_reg_write,
  input  logic          id_mem_read,
  input  logic          id_mem_write,
  input  logic          id_mem_to_reg,
  input  logic          exm_reg_write,
  input  logic [RW-1:0] exm_rd,
  input  logic [DW-1:0] exm_result,
  input  logic          mwb_reg_write,
  input  logic [RW-1:0] mwb_rd,
  input  logic [DW-1:0] mwb_result,
  output logic          hazard_stall,
  output logic [DW-1:0] alu_a,
  output logic [DW-1:0] alu_b,
  output logic [2:0]    alu_ctrl,
  output logic [DW-1:0] ex_store_data,
  output logic [RW-1:0] ex_dest,
  output logic          ex_reg_write,
  output logic          ex_mem_read,
  output logic          ex_mem_write,
  output logic          ex_mem_to_reg
);

  logic [RW-1:0] rs_q, rs_d;
  logic [RW-1:0] rt_q, rt_d;
  logic [RW-1:0] dest_q, dest_d;
  logic [DW-1:0] rs_data_q, rs_data_d;
  logic [DW-1:0] rt_data_q, rt_data_d;
  logic [DW-1:0] imm_q, imm_d;
  logic          alu_src_q, alu_src_d;
  logic [2:0]    alu_ctrl_q, alu_ctrl_d;
  logic          reg_write_q, reg_write_d;
  logic          mem_read_q, mem_read_d;
  logic          mem_write_q, mem_write_d;
  logic          mem_to_reg_q, mem_to_reg_d;

  logic [DW-1:0] fwd_a;
  logic [DW-1:0] fwd_b;

  // Load-use detect: a load in EX whose destination is read by the
  // instruction now in ID. The bubble it inserts clears mem_read_q, so the
  // stall lasts for one cycle only.
  always_comb begin
    hazard_stall = 1'b0;
    if (mem_read_q && (dest_q != '0) &&
        ((dest_q == id_rs) || (dest_q == id_rt))) begin
      hazard_stall = 1'b1;
    end
  end

  // Next-state selection: capture ID, or insert a bubble on flush/stall.
  always_comb begin
    rs_d         = id_rs;
    rt_d         = id_rt;
    dest_d       = id_reg_dst ? id_rd : id_rt;
    rs_data_d    = id_rs_data;
    rt_data_d    = id_rt_data;
    imm_d        = id_imm;
    alu_src_d    = id_alu_src;
    alu_ctrl_d   = id_alu_ctrl;
    reg_write_d  = id_reg_write;
    mem_read_d   = id_mem_read;
    mem_write_d  = id_mem_write;
    mem_to_reg_d = id_mem_to_reg;
    if (flush || hazard_stall) begin
      rs_d         = '0;
      rt_d         = '0;
      dest_d       = '0;
      rs_data_d    = '0;
      rt_data_d    = '0;
      imm_d        = '0;
      alu_src_d    = 1'b0;
      alu_ctrl_d   = 3'b000;
      reg_write_d  = 1'b0;
      mem_read_d   = 1'b0;
      mem_write_d  = 1'b0;
      mem_to_reg_d = 1'b0;
    end
  end

  // ID/EX pipeline register. Async reset gives a bubble immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rs_q         <= '0;
      rt_q         <= '0;
      dest_q       <= '0;
      rs_data_q    <= '0;
      rt_data_q    <= '0;
      imm_q        <= '0;
      alu_src_q    <= 1'b0;
      alu_ctrl_q   <= 3'b000;
      reg_write_q  <= 1'b0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_to_reg_q <= 1'b0;
    end else begin
      rs_q         <= rs_d;
      rt_q         <= rt_d;
      dest_q       <= dest_d;
      rs_data_q    <= rs_data_d;
      rt_data_q    <= rt_data_d;
      imm_q        <= imm_d;
      alu_src_q    <= alu_src_d;
      alu_ctrl_q   <= alu_ctrl_d;
      reg_write_q  <= reg_write_d;
      mem_read_q   <= mem_read_d;
      mem_write_q  <= mem_write_d;
      mem_to_reg_q <= mem_to_reg_d;
    end
  end

  // Operand A forwarding: r0 is always zero, and EX/MEM beats MEM/WB.
  // The address-equality test already excludes rd=0 once rs is nonzero.
  always_comb begin
    fwd_a = rs_data_q;
    if (rs_q == '0) begin
      fwd_a = '0;
    end else if (exm_reg_write && (exm_rd == rs_q)) begin
      fwd_a = exm_result;
    end else if (mwb_reg_write && (mwb_rd == rs_q)) begin
      fwd_a = mwb_result;
    end
  end

  // Operand B / store data forwarding, same priority rules on rt.
  always_comb begin
    fwd_b = rt_data_q;
    if (rt_q == '0) begin
      fwd_b = '0;
    end else if (exm_reg_write && (exm_rd == rt_q)) begin
      fwd_b = exm_result;
    end else if (mwb_reg_write && (mwb_rd == rt_q)) begin
      fwd_b = mwb_result;
    end
  end

  assign alu_a         = fwd_a;
  assign ex_store_data = fwd_b;
  assign alu_b         = alu_src_q ? imm_q : fwd_b;
  assign alu_ctrl      = alu_ctrl_q;
  assign ex_dest       = dest_q;
  assign ex_reg_write  = reg_write_q;
  assign ex_mem_read   = mem_read_q;
  assign ex_mem_write  = mem_write_q;
  assign ex_mem_to_reg = mem_to_reg_q;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Bench for id_ex_operand_stage: directed scenarios with literal
// expectations, then random instruction streams against a reference model.
module tb_id_ex_operand_stage;

  localparam int DW = 16;
  localparam int RW = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          flush;
  logic [DW-1:0] id_rs_data, id_rt_data, id_imm;
  logic [RW-1:0] id_rs, id_rt, id_rd;
  logic          id_alu_src, id_reg_dst;
  logic [2:0]    id_alu_ctrl;
  logic          id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg;
  logic          exm_reg_write;
  logic [RW-1:0] exm_rd;
  logic [DW-1:0] exm_result;
  logic          mwb_reg_write;
  logic [RW-1:0] mwb_rd;
  logic [DW-1:0] mwb_result;
  logic          hazard_stall;
  logic [DW-1:0] alu_a, alu_b, ex_store_data;
  logic [2:0]    alu_ctrl;
  logic [RW-1:0] ex_dest;
  logic          ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg;

  int n_tests = 0;
  int n_fail  = 0;

  id_ex_operand_stage #(.DW(DW), .RW(RW)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .id_alu_src(id_alu_src), .id_reg_dst(id_reg_dst), .id_alu_ctrl(id_alu_ctrl),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .id_mem_write(id_mem_write), .id_mem_to_reg(id_mem_to_reg),
    .exm_reg_write(exm_reg_write), .exm_rd(exm_rd), .exm_result(exm_result),
    .mwb_reg_write(mwb_reg_write), .mwb_rd(mwb_rd), .mwb_result(mwb_result),
    .hazard_stall(hazard_stall), .alu_a(alu_a), .alu_b(alu_b),
    .alu_ctrl(alu_ctrl), .ex_store_data(ex_store_data), .ex_dest(ex_dest),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write), .ex_mem_to_reg(ex_mem_to_reg)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- drivers ----------------
  task automatic idle_inputs();
    flush = 0; id_rs_data = '0; id_rt_data = '0; id_imm = '0;
    id_rs = '0; id_rt = '0; id_rd = '0; id_alu_src = 0; id_reg_dst = 0;
    id_alu_ctrl = '0; id_reg_write = 0; id_mem_read = 0; id_mem_write = 0;
    id_mem_to_reg = 0; exm_reg_write = 0; exm_rd = '0; exm_result = '0;
    mwb_reg_write = 0; mwb_rd = '0; mwb_result = '0;
  endtask

  task automatic after_edge();
    @(posedge clk);
    #1;
  endtask

  // ---------------- reference model ----------------
  // What the ID/EX register holds, viewed as "the instruction now in EX".
  typedef struct packed {
    logic [RW-1:0] rs, rt, dest;
    logic [DW-1:0] rs_data, rt_data, imm;
    logic          alu_src;
    logic [2:0]    ctrl;
    logic          rw, mr, mw, m2r;
  } instr_t;

  instr_t ex_instr;

  // Value of a register as seen in EX, following the newest producer.
  function automatic logic [DW-1:0] read_reg(input logic [RW-1:0] a,
                                             input logic [DW-1:0] stale);
    if (a == 0) return '0;
    if (exm_reg_write && exm_rd == a) return exm_result;
    if (mwb_reg_write && mwb_rd == a) return mwb_result;
    return stale;
  endfunction

  function automatic logic model_stall();
    return ex_instr.mr && ex_instr.dest != 0 &&
           (ex_instr.dest == id_rs || ex_instr.dest == id_rt);
  endfunction

  task automatic compare_all();
    logic [DW-1:0] b;
    b = read_reg(ex_instr.rt, ex_instr.rt_data);
    check("stall", hazard_stall, model_stall());
    check("alu_a", alu_a, read_reg(ex_instr.rs, ex_instr.rs_data));
    check("store_data", ex_store_data, b);
    check("alu_b", alu_b, ex_instr.alu_src ? ex_instr.imm : b);
    check("alu_ctrl", alu_ctrl, ex_instr.ctrl);
    check("ex_dest", ex_dest, ex_instr.dest);
    check("ex_ctrl", {ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg},
          {ex_instr.rw, ex_instr.mr, ex_instr.mw, ex_instr.m2r});
  endtask

  task automatic model_advance();
    instr_t nxt;
    if (flush || model_stall()) begin
      nxt = '0;
    end else begin
      nxt.rs = id_rs; nxt.rt = id_rt;
      nxt.dest = id_reg_dst ? id_rd : id_rt;
      nxt.rs_data = id_rs_data; nxt.rt_data = id_rt_data; nxt.imm = id_imm;
      nxt.alu_src = id_alu_src; nxt.ctrl = id_alu_ctrl;
      nxt.rw = id_reg_write; nxt.mr = id_mem_read;
      nxt.mw = id_mem_write; nxt.m2r = id_mem_to_reg;
    end
    ex_instr = nxt;
  endtask

  task automatic random_inputs();
    id_rs_data = DW'($urandom); id_rt_data = DW'($urandom); id_imm = DW'($urandom);
    id_rs = RW'($urandom_range(0, 7)); id_rt = RW'($urandom_range(0, 7));
    id_rd = RW'($urandom_range(0, 7));
    id_alu_src = 1'($urandom); id_reg_dst = 1'($urandom);
    id_alu_ctrl = 3'($urandom);
    id_reg_write = 1'($urandom); id_mem_read = ($urandom_range(0, 2) == 0);
    id_mem_write = 1'($urandom); id_mem_to_reg = 1'($urandom);
    flush = ($urandom_range(0, 9) == 0);
    exm_reg_write = 1'($urandom); exm_rd = RW'($urandom_range(0, 7));
    exm_result = DW'($urandom);
    mwb_reg_write = 1'($urandom); mwb_rd = RW'($urandom_range(0, 7));
    mwb_result = DW'($urandom);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    idle_inputs();
    ex_instr = '0;
    #2;
    // reset state while held in reset
    check("rst_alu_a", alu_a, 0);
    check("rst_alu_b", alu_b, 0);
    check("rst_store", ex_store_data, 0);
    check("rst_ctrl", alu_ctrl, 0);
    check("rst_dest", ex_dest, 0);
    check("rst_exctl", {ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg}, 0);
    check("rst_stall", hazard_stall, 0);
    @(negedge clk);
    rst_n = 1;

    // 1. reset mid-operation
    @(negedge clk);
    id_rs = 3'd1; id_rs_data = 16'h1234; id_reg_write = 1; id_mem_write = 1;
    after_edge();
    check("t1_loaded", alu_a, 16'h1234);
    @(negedge clk); #2;
    rst_n = 0; #1;
    check("t1_rst_alu_a", alu_a, 0);
    check("t1_rst_ctl", {ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg}, 0);
    @(negedge clk);
    rst_n = 1;
    idle_inputs();

    // 2. back-to-back dependency, EX/MEM priority
    @(negedge clk);
    id_rs = 3'd3; id_rs_data = 16'h1111;
    after_edge();
    exm_reg_write = 1; exm_rd = 3'd3; exm_result = 16'h00AA;
    mwb_reg_write = 1; mwb_rd = 3'd3; mwb_result = 16'h0055;
    #1 check("t2_exm_prio", alu_a, 16'h00AA);
    exm_reg_write = 0;
    #1 check("t2_mwb", alu_a, 16'h0055);
    mwb_reg_write = 0;
    #1 check("t2_regfile", alu_a, 16'h1111);
    idle_inputs();

    // 3. immediate select with forwarded store data
    @(negedge clk);
    id_alu_src = 1; id_imm = 16'hFFF0; id_rt = 3'd2; id_rt_data = 16'h1234;
    after_edge();
    exm_reg_write = 1; exm_rd = 3'd2; exm_result = 16'h0007;
    #1 check("t3_alu_b", alu_b, 16'hFFF0);
    check("t3_store", ex_store_data, 16'h0007);
    idle_inputs();

    // 4. load-use stall for exactly one cycle
    @(negedge clk);
    id_mem_read = 1; id_reg_write = 1; id_mem_to_reg = 1; id_reg_dst = 0;
    id_rt = 3'd4; id_rs = 3'd1;
    after_edge();
    idle_inputs();
    id_rs = 3'd4; id_rt = 3'd5; id_reg_write = 1;
    #1 check("t4_stall", hazard_stall, 1);
    check("t4_dest", ex_dest, 3'd4);
    after_edge();
    check("t4_bubble", {ex_mem_read, ex_reg_write}, 2'b00);
    check("t4_stall_off", hazard_stall, 0);
    after_edge();
    check("t4_consumer", {ex_reg_write, 1'b0, ex_dest}, {1'b1, 1'b0, 3'd5});
    idle_inputs();

    // 5. r0 guard
    @(negedge clk);
    id_rs = 3'd0; id_rs_data = 16'h7777;
    after_edge();
    exm_reg_write = 1; exm_rd = 3'd0; exm_result = 16'hBEEF;
    mwb_reg_write = 1; mwb_rd = 3'd0; mwb_result = 16'hCAFE;
    #1 check("t5_r0_fwd", alu_a, 0);
    idle_inputs();
    @(negedge clk);
    id_mem_read = 1; id_reg_write = 1; id_reg_dst = 1; id_rd = 3'd0; id_rt = 3'd5;
    after_edge();
    idle_inputs();
    #1 check("t5_r0_stall", hazard_stall, 0);

    // 6. flush, then the same instruction without flush
    @(negedge clk);
    id_reg_write = 1; id_alu_ctrl = 3'b110; id_reg_dst = 1; id_rd = 3'd5;
    flush = 1;
    after_edge();
    check("t6_flush_rw", ex_reg_write, 0);
    check("t6_flush_ctrl", alu_ctrl, 3'b000);
    check("t6_flush_dest", ex_dest, 0);
    @(negedge clk);
    flush = 0;
    after_edge();
    check("t6_ctrl", alu_ctrl, 3'b110);
    check("t6_dest", ex_dest, 3'd5);
    idle_inputs();

    // random phase: fresh reset, model starts at a bubble
    @(negedge clk);
    rst_n = 0;
    #1 rst_n = 1;
    ex_instr = '0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      random_inputs();
      #1;
      compare_all();
      @(posedge clk);
      model_advance();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // global time limit
  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
